serial_add_ctrl: RTL
====================

Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract sequencer that time-shares one external single-bit full_adder instance across WIDTH clock cycles.
- Holds the operand and result shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Drives the full adder's a/b/c inputs and samples its sum/carry outputs. It is the LSB-first serial arithmetic unit of the 7400-style datapath, where one physical adder stage replaces a WIDTH-bit ripple chain.

Parameters:
- WIDTH, 8, operand/result width in bits; legal values are 2 to 32.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op_sub  input  1  0 = add (a_in + b_in + cin); 1 = subtract (a_in - b_in); sampled with start.
- a_in  input  WIDTH  operand A; sampled with start.
- b_in  input  WIDTH  operand B; sampled with start.
- cin  input  1  carry in for add; ignored when op_sub=1; sampled with start.
- fa_a  output  1  to full_adder a input.
- fa_b  output  1  to full_adder b input.
- fa_c  output  1  to full_adder carry-in input.
- fa_s  input  1  from full_adder sum output.
- fa_cout  input  1  from full_adder carry-out output.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result is complete.
- sum  output  WIDTH  result register.
- cout  output  1  final carry out; for subtract, 1 means no borrow.
- ovf  output  1  two's-complement overflow of the final result.

Behaviour:
- Reset (rst_n low, asynchronous, dominant at any time including mid-operation):
  - state=IDLE; all shift registers, carry, counter, sum, cout and ovf cleared to 0.
  - busy=0, done=0, fa_a=fa_b=fa_c=0.
  - No operation resumes after reset; a new start is required.
- States:
  - IDLE: wait for start.
  - RUN: process one bit per cycle.
  - DONE: single cycle, then IDLE.
- IDLE, start=1 at a rising edge:
  - Load A=a_in.
  - Load B=op_sub ? ~b_in : b_in.
  - Load carry=op_sub ? 1 : cin.
  - count=0; state goes to RUN.
  - sum, cout and ovf keep their previous values until overwritten in RUN.
  - With start=0, the block stays in IDLE and all registers hold.
- RUN:
  - Combinational outputs: fa_a=A[0], fa_b=B[0], fa_c=carry.
  - Each rising edge: A and B shift right by 1; fa_s shifts into sum[WIDTH-1] while sum shifts right; carry<=fa_cout; count increments.
  - On the edge where count==WIDTH-1: cout<=fa_cout, ovf<=carry^fa_cout (carry into MSB xor carry out of MSB), state goes to DONE.
  - start is ignored in RUN, with no queuing.
- DONE:
  - done=1 and busy=0 for exactly one cycle; then IDLE on the next edge.
  - start is ignored in DONE.
- fa_a, fa_b and fa_c are 0 in IDLE and DONE.
- Latency: if start is accepted at edge k, busy is high from k to k+WIDTH and done is high between edges k+WIDTH and k+WIDTH+1. Minimum start-to-start spacing is WIDTH+2 cycles.
- Results:
  - sum, cout and ovf are valid when done=1.
  - They hold stable until the first RUN edge of the next operation.
  - During RUN, sum is a partial value and must not be used.
- Arithmetic: result = (A + B' + carry0) mod 2^WIDTH, where B' and carry0 are the values loaded at start. Carry wrap-around beyond the MSB appears only on cout.
- Operand inputs may change freely after the start edge, because the loaded copies are used.

Test Plan:
- Add, WIDTH=8: a_in=0x5A, b_in=0x33, cin=0, op_sub=0 -> after 8 busy cycles, done pulse with sum=0x8D, cout=0, ovf=1; full_adder driven bit-serially LSB first.
- Add wrap: a_in=0xFF, b_in=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. With cin=1 instead -> sum=0x01, cout=1.
- Subtract: op_sub=1, a_in=0x10, b_in=0x20 -> sum=0xF0, cout=0 (borrow), ovf=0. op_sub=1, a_in=0x80, b_in=0x01 -> sum=0x7F, cout=1, ovf=1.
- Handshake: start held high continuously with a_in=0x01, b_in=0x02 -> busy high exactly 8 cycles, done high exactly 1 cycle, next operation accepted in the IDLE cycle after DONE (spacing 10 cycles). Operand changes mid-RUN do not affect the result (sum=0x03).
- Reset mid-operation: assert rst_n=0 asynchronously after 4 RUN cycles -> busy, done, sum, cout, ovf and fa_* go to 0 immediately without waiting for a clock. No done pulse after release; a fresh start gives the correct result.
- Exhaustive check at WIDTH=4: all 16×16×2 add/sub combinations with cin=0 and 1 -> sum, cout and ovf match the reference arithmetic model.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
// ---------------
// Bit-serial add/subtract sequencer. A single external one-bit full adder is
// reused over WIDTH clock cycles, LSB first. This block holds the operand and
// result shift registers, the carry flip-flop, the bit counter and the
// start/busy/done handshake.
//
// Subtraction is A + ~B + 1. The operand is inverted and the carry is preset
// at load time, so the RUN loop is the same for add and subtract.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   start    in   begin an operation (accepted in IDLE only)
//   op_sub   in   0 = a_in + b_in + cin, 1 = a_in - b_in
//   a_in     in   [WIDTH] operand A
//   b_in     in   [WIDTH] operand B
//   cin      in   carry in for add (ignored for subtract)
//   fa_a     out  full adder a input  (A[0] in RUN, else 0)
//   fa_b     out  full adder b input  (B[0] in RUN, else 0)
//   fa_c     out  full adder carry in (carry in RUN, else 0)
//   fa_s     in   full adder sum
//   fa_cout  in   full adder carry out
//   busy     out  high while processing bits
//   done     out  one-cycle completion pulse
//   sum      out  [WIDTH] result
//   cout     out  final carry (for subtract, 1 = no borrow)
//   ovf      out  two's-complement overflow
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin,
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c,
    input  logic             fa_s,
    input  logic             fa_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             carry_reg, carry_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH-1:0] sum_reg, sum_next;
    logic             cout_reg, cout_next;
    logic             ovf_reg, ovf_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            count_reg <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            count_reg <= count_next;
            sum_reg   <= sum_next;
            cout_reg  <= cout_next;
            ovf_reg   <= ovf_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        count_next = count_reg;
        sum_next   = sum_reg;
        cout_next  = cout_reg;
        ovf_next   = ovf_reg;
        fa_a       = 1'b0;
        fa_b       = 1'b0;
        fa_c       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    a_next     = a_in;
                    b_next     = op_sub ? ~b_in : b_in;
                    carry_next = op_sub ? 1'b1 : cin;
                    count_next = '0;
                    state_next = S_RUN;
                end
            end

            S_RUN: begin
                busy       = 1'b1;
                fa_a       = a_reg[0];
                fa_b       = b_reg[0];
                fa_c       = carry_reg;
                a_next     = {1'b0, a_reg[WIDTH-1:1]};
                b_next     = {1'b0, b_reg[WIDTH-1:1]};
                sum_next   = {fa_s, sum_reg[WIDTH-1:1]};
                carry_next = fa_cout;
                count_next = count_reg + CW'(1);
                if (count_reg == CW'(WIDTH - 1)) begin
                    // carry_reg is the carry into the MSB on this last edge.
                    cout_next  = fa_cout;
                    ovf_next   = carry_reg ^ fa_cout;
                    state_next = S_DONE;
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign sum  = sum_reg;
    assign cout = cout_reg;
    assign ovf  = ovf_reg;

endmodule
